// File: rtl/cache_pkg.sv
// Shared types and helpers for the fully associative write-back cache.
package cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StRefill,
        StResp,
        StFlushScan,
        StFlushWb
    } cache_state_e;

    typedef struct packed {
        logic valid;
        logic dirty;
    } line_flags_t;

    function automatic int unsigned age_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_tracker.sv
// True-LRU age array: ages stay a permutation of 0..WAYS-1, 0 = most recently used.
module cache_lru_tracker
    import cache_pkg::*;
#(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned AGE_W = age_w(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             touch_i,
    input  logic [AGE_W-1:0] touch_way_i,
    input  logic [WAYS-1:0]  valid_i,
    output logic [AGE_W-1:0] victim_o
);

    logic [AGE_W-1:0] age_q [WAYS];
    logic [AGE_W-1:0] age_d [WAYS];

    always_comb begin
        age_d = age_q;
        if (touch_i) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[w] < age_q[touch_way_i]) age_d[w] = age_q[w] + 1'b1;
            end
            age_d[touch_way_i] = '0;
        end
    end

    // Lowest-index invalid way wins; otherwise the oldest way.
    always_comb begin
        victim_o = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[w] == AGE_W'(WAYS - 1)) victim_o = AGE_W'(w);
        end
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (!valid_i[i]) victim_o = AGE_W'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned w = 0; w < WAYS; w++) age_q[w] <= AGE_W'(w);
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/cache_assoc_wb.sv
// Fully associative write-back cache, one word per line, true-LRU, with flush and counters.
module cache_assoc_wb
    import cache_pkg::*;
#(
    parameter int unsigned WAYS   = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock_in,
    input  logic              reset_n_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_wren_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic              resp_valid_out,
    output logic [DATA_W-1:0] resp_data_out,
    output logic              resp_hit_out,
    input  logic              flush_in,
    output logic              flush_done_out,
    output logic              mem_req_out,
    output logic              mem_wren_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_ack_in,
    output logic [CNT_W-1:0]  hit_count_out,
    output logic [CNT_W-1:0]  miss_count_out
);

    localparam int unsigned AGE_W  = age_w(WAYS);
    localparam int unsigned SCAN_W = AGE_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] tag;
        line_flags_t       flags;
        logic [DATA_W-1:0] data;
    } line_t;

    cache_state_e      state_q, state_d;
    line_t             lines_q [WAYS];
    line_t             lines_d [WAYS];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              wren_q, wren_d, hit_q, hit_d;
    logic [AGE_W-1:0]  way_q, way_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    logic              lookup_hit, touch, scan_end, accept;
    logic [AGE_W-1:0]  hit_way, victim, touch_way, scan_way;
    logic [WAYS-1:0]   valid_vec;

    assign scan_way  = scan_q[AGE_W-1:0];
    assign scan_end  = (scan_q == SCAN_W'(WAYS));
    assign accept    = req_valid_in && req_ready_out;
    assign touch     = (state_q == StLookup && lookup_hit) || (state_q == StRefill && mem_ack_in);
    assign touch_way = (state_q == StLookup) ? hit_way : way_q;

    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            valid_vec[w] = lines_q[w].flags.valid;
            if (lines_q[w].flags.valid && lines_q[w].tag == addr_q) begin
                lookup_hit = 1'b1;
                hit_way    = AGE_W'(w);
            end
        end
    end

    cache_lru_tracker #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .clk_i       (clock_in),
        .rst_ni      (reset_n_in),
        .touch_i     (touch),
        .touch_way_i (touch_way),
        .valid_i     (valid_vec),
        .victim_o    (victim)
    );

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= StIdle;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (flush_in)          state_d = StFlushScan;
                else if (req_valid_in) state_d = StLookup;
            end
            StLookup: begin
                if (lookup_hit) state_d = StResp;
                else if (lines_q[victim].flags.valid && lines_q[victim].flags.dirty)
                    state_d = StWriteback;
                else state_d = StRefill;
            end
            StWriteback: if (mem_ack_in) state_d = StRefill;
            StRefill:    if (mem_ack_in) state_d = StResp;
            StResp:      state_d = StIdle;
            StFlushScan: begin
                if (scan_end) state_d = StIdle;
                else if (lines_q[scan_way].flags.valid && lines_q[scan_way].flags.dirty)
                    state_d = StFlushWb;
            end
            StFlushWb:   if (mem_ack_in) state_d = StFlushScan;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_out  = (state_q == StIdle) && !flush_in;
        resp_valid_out = (state_q == StResp);
        resp_data_out  = (state_q == StResp) ? rdata_q : '0;
        resp_hit_out   = (state_q == StResp) && hit_q;
        flush_done_out = (state_q == StFlushScan) && scan_end;
        mem_req_out    = 1'b0;
        mem_wren_out   = 1'b0;
        mem_addr_out   = '0;
        mem_data_out   = '0;
        unique case (state_q)
            StWriteback: begin
                mem_req_out  = 1'b1;
                mem_wren_out = 1'b1;
                mem_addr_out = lines_q[way_q].tag;
                mem_data_out = lines_q[way_q].data;
            end
            StFlushWb: begin
                mem_req_out  = 1'b1;
                mem_wren_out = 1'b1;
                mem_addr_out = lines_q[scan_way].tag;
                mem_data_out = lines_q[scan_way].data;
            end
            StRefill: begin
                mem_req_out  = 1'b1;
                mem_addr_out = addr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        lines_d    = lines_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wren_d     = wren_q;
        rdata_d    = rdata_q;
        hit_d      = hit_q;
        way_d      = way_q;
        scan_d     = scan_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            StIdle: begin
                scan_d = '0;
                if (accept) begin
                    addr_d  = req_addr_in;
                    wdata_d = req_data_in;
                    wren_d  = req_wren_in;
                end
            end
            StLookup: begin
                if (lookup_hit) begin
                    hit_d   = 1'b1;
                    way_d   = hit_way;
                    rdata_d = wren_q ? wdata_q : lines_q[hit_way].data;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    if (wren_q) begin
                        lines_d[hit_way].data        = wdata_q;
                        lines_d[hit_way].flags.dirty = 1'b1;
                    end
                end else begin
                    hit_d = 1'b0;
                    way_d = victim;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                end
            end
            StWriteback: if (mem_ack_in) lines_d[way_q].flags.dirty = 1'b0;
            StRefill: begin
                if (mem_ack_in) begin
                    lines_d[way_q].tag         = addr_q;
                    lines_d[way_q].flags.valid = 1'b1;
                    lines_d[way_q].flags.dirty = wren_q;
                    lines_d[way_q].data        = wren_q ? wdata_q : mem_data_in;
                    rdata_d                    = wren_q ? wdata_q : mem_data_in;
                end
            end
            StFlushScan: begin
                if (!scan_end &&
                    !(lines_q[scan_way].flags.valid && lines_q[scan_way].flags.dirty))
                    scan_d = scan_q + 1'b1;
            end
            StFlushWb: begin
                if (mem_ack_in) begin
                    lines_d[scan_way].flags.dirty = 1'b0;
                    scan_d                        = scan_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int unsigned w = 0; w < WAYS; w++) lines_q[w] <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            way_q      <= '0;
            scan_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            lines_q    <= lines_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            way_q      <= way_d;
            scan_q     <= scan_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed and random checks of cache_assoc_wb against a recency-list cache model.
module tb_cache_assoc_wb;

    localparam int WAYS = 4;
    localparam int CMAX = 15;

    logic       clk, rst_n;
    logic       req_valid, req_ready, req_wren;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid, resp_hit;
    logic [7:0] resp_data;
    logic       flush, flush_done;
    logic       mem_req, mem_wren, mem_ack;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [3:0] hit_count, miss_count;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [32];
    logic [7:0]  ref_mem [32];
    logic [13:0] mem_log [$];
    logic [13:0] exp_log [$];
    bit          hold_ack = 0;
    int          fixed_delay = 3;

    logic [4:0]  m_tag [WAYS];
    logic [7:0]  m_data [WAYS];
    bit          m_valid [WAYS];
    bit          m_dirty [WAYS];
    int          lru [$];
    int          m_hits, m_misses;

    cache_assoc_wb #(
        .WAYS   (4),
        .ADDR_W (5),
        .DATA_W (8),
        .CNT_W  (4)
    ) dut (
        .clock_in       (clk),
        .reset_n_in     (rst_n),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_wren_in    (req_wren),
        .req_addr_in    (req_addr),
        .req_data_in    (req_wdata),
        .resp_valid_out (resp_valid),
        .resp_data_out  (resp_data),
        .resp_hit_out   (resp_hit),
        .flush_in       (flush),
        .flush_done_out (flush_done),
        .mem_req_out    (mem_req),
        .mem_wren_out   (mem_wren),
        .mem_addr_out   (mem_addr),
        .mem_data_out   (mem_wdata),
        .mem_data_in    (mem_rdata),
        .mem_ack_in     (mem_ack),
        .hit_count_out  (hit_count),
        .miss_count_out (miss_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    // Main memory: acks after a delay, logs every completed transaction.
    initial begin
        int cnt;
        bit busy;
        mem_ack = 0; mem_rdata = 0; busy = 0; cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 0;
                busy = 0;
            end else if (mem_req !== 1'b1 || !rst_n) begin
                busy = 0;
            end else if (!hold_ack) begin
                if (!busy) begin
                    busy = 1;
                    cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    mem_ack = 1;
                    if (mem_wren) begin
                        mem[mem_addr] = mem_wdata;
                        mem_log.push_back({1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem[mem_addr];
                        mem_log.push_back({1'b0, mem_addr, mem[mem_addr]});
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++) begin
            m_valid[w] = 0;
            m_dirty[w] = 0;
        end
        lru = {0, 1, 2, 3};
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_touch(input int k);
        int idx = 0;
        foreach (lru[i]) if (lru[i] == k) idx = i;
        lru.delete(idx);
        lru.push_front(k);
    endtask

    task automatic model_access(input bit wr, input logic [4:0] a, input logic [7:0] d,
                                output bit hit, output logic [7:0] data);
        int k = -1;
        for (int w = 0; w < WAYS; w++) if (m_valid[w] && m_tag[w] == a) k = w;
        hit = (k >= 0);
        if (hit) begin
            if (m_hits < CMAX) m_hits++;
            if (wr) begin
                m_data[k] = d;
                m_dirty[k] = 1;
            end
        end else begin
            if (m_misses < CMAX) m_misses++;
            k = lru[$];
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w]) k = w;
            if (m_valid[k] && m_dirty[k]) begin
                exp_log.push_back({1'b1, m_tag[k], m_data[k]});
                ref_mem[m_tag[k]] = m_data[k];
            end
            exp_log.push_back({1'b0, a, ref_mem[a]});
            m_tag[k] = a;
            m_valid[k] = 1;
            m_dirty[k] = wr;
            m_data[k] = wr ? d : ref_mem[a];
        end
        data = m_data[k];
        model_touch(k);
    endtask

    task automatic check_log();
        check("mem_log_len", mem_log.size(), exp_log.size());
        for (int i = 0; i < mem_log.size() && i < exp_log.size(); i++)
            check("mem_log_entry", mem_log[i], exp_log[i]);
        mem_log.delete();
        exp_log.delete();
    endtask

    task automatic check_counts();
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", req_ready, 1);
    endtask

    task automatic access(input bit wr, input logic [4:0] a, input logic [7:0] d);
        bit eh;
        logic [7:0] ed;
        int lat;
        model_access(wr, a, d, eh, ed);
        wait_ready();
        req_valid = 1; req_wren = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("resp_valid", resp_valid, 1);
        check("resp_hit", resp_hit, eh);
        check("resp_data", resp_data, ed);
        if (eh) check("hit_latency", lat, 2);
        @(negedge clk);
        check("resp_one_cycle", resp_valid, 0);
        check_log();
        check_counts();
    endtask

    task automatic do_flush();
        int pulses = 0;
        bit ready_seen = 0;
        bit done = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[w] && m_dirty[w]) begin
                exp_log.push_back({1'b1, m_tag[w], m_data[w]});
                ref_mem[m_tag[w]] = m_data[w];
                m_dirty[w] = 0;
            end
        end
        wait_ready();
        flush = 1;
        @(negedge clk);
        flush = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            if (req_ready) ready_seen = 1;
            if (flush_done) begin
                pulses++;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        check("flush_done_seen", pulses, 1);
        check("ready_low_in_flush", ready_seen, 0);
        @(negedge clk);
        check("flush_done_one_cycle", flush_done, 0);
        check_log();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        mem_log.delete();
        exp_log.delete();
    endtask

    initial begin
        logic [7:0] v;
        logic [4:0] fresh, prev;
        int n;
        rst_n = 0; req_valid = 0; req_wren = 0; req_addr = 0; req_wdata = 0; flush = 0;
        for (int i = 0; i < 32; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[5'h14] = 8'h5A;
        ref_mem[5'h14] = 8'h5A;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Read miss then hit, write hit, read back.
        access(0, 5'h14, 8'h00);
        access(0, 5'h14, 8'h00);
        access(1, 5'h14, 8'hC3);
        access(0, 5'h14, 8'h00);

        // Clean LRU victim.
        do_reset();
        access(0, 5'h01, 0); access(0, 5'h02, 0); access(0, 5'h03, 0); access(0, 5'h04, 0);
        access(0, 5'h01, 0); access(0, 5'h05, 0);

        // Dirty LRU victim: write-back then refill.
        do_reset();
        access(0, 5'h01, 0); access(0, 5'h02, 0); access(1, 5'h02, 8'h77);
        access(0, 5'h03, 0); access(0, 5'h04, 0); access(0, 5'h01, 0);
        access(0, 5'h05, 0);

        // Dirty ways 1 and 3, flush, then evict them cleanly.
        access(1, 5'h05, 8'hA1);
        access(1, 5'h04, 8'hB2);
        do_flush();
        access(0, 5'h06, 0); access(0, 5'h07, 0); access(0, 5'h08, 0); access(0, 5'h09, 0);

        // Random traffic with random memory latency; counters saturate.
        fixed_delay = -1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) do_flush();
            else access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), 8'($urandom));
        end

        // Reset in the middle of a refill.
        do_flush();
        fresh = 0;
        prev = 0;
        for (int a = 31; a >= 0; a--) begin
            bit present = 0;
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[w] && m_tag[w] == 5'(a)) begin
                    present = 1;
                    prev = 5'(a);
                end
            end
            if (!present) fresh = 5'(a);
        end
        hold_ack = 1;
        wait_ready();
        req_valid = 1; req_wren = 0; req_addr = fresh; req_wdata = 0;
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!(mem_req === 1'b1 && mem_wren === 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("refill_reached", mem_req, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_hits", hit_count, 0);
        check("async_rst_misses", miss_count, 0);
        check("async_rst_ready", req_ready, 1);
        model_reset();
        mem_log.delete();
        exp_log.delete();
        hold_ack = 0;
        @(negedge clk);
        rst_n = 1;
        access(0, prev, 0);
        check("post_reset_miss_count", miss_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
